// File: rtl/vrf_bank_rd_arb_pkg.sv
// Shared vector-register-file parameters and read request/response records.
package vrf_bank_rd_arb_pkg;
  localparam int VRF_RPORT_NUM     = 5;
  localparam int VRF_BANK_NUM      = 4;
  localparam int VRF_PREBANK_RPORT = 2;
  localparam int VERG_ADDR_WIDTH   = 6;
  localparam int VFULEN            = 256;
  localparam int VRF_TAG_W         = 18;

  typedef struct packed {
    logic [VERG_ADDR_WIDTH-1:0] addr;
    logic [VRF_TAG_W-1:0]       tag;
  } vrf_rd_req_t;

  typedef struct packed {
    logic [VFULEN-1:0]    data;
    logic [VRF_TAG_W-1:0] tag;
  } vrf_rd_rsp_t;
endpackage

// File: rtl/vrf_bank_slot_alloc.sv
// One bank: round-robin scan over ports, merging same-row reads into one slot.
module vrf_bank_slot_alloc
  import vrf_bank_rd_arb_pkg::*;
#(
  parameter int RPORT_NUM  = VRF_RPORT_NUM,
  parameter int BANK_RPORT = VRF_PREBANK_RPORT,
  parameter int ROW_W      = 4,
  localparam int PTR_W     = (RPORT_NUM > 1) ? $clog2(RPORT_NUM) : 1,
  localparam int SLOT_W    = (BANK_RPORT > 1) ? $clog2(BANK_RPORT) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 flush,
  input  logic [RPORT_NUM-1:0]                 hit,
  input  logic [RPORT_NUM-1:0][ROW_W-1:0]      row,
  output logic [RPORT_NUM-1:0]                 gnt,
  output logic [RPORT_NUM-1:0][SLOT_W-1:0]     gnt_slot,
  output logic [BANK_RPORT-1:0]                re,
  output logic [BANK_RPORT-1:0][ROW_W-1:0]     raddr
);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(RPORT_NUM - 1);

  logic [PTR_W-1:0] ptr, ptr_nxt;

  always_comb begin
    logic [PTR_W-1:0] p;
    logic             done;
    gnt      = '0;
    gnt_slot = '0;
    re       = '0;
    raddr    = '0;
    ptr_nxt  = ptr;
    p        = ptr;
    done     = 1'b0;
    for (int k = 0; k < RPORT_NUM; k++) begin
      if (hit[p] && !flush) begin
        done = 1'b0;
        for (int s = 0; s < BANK_RPORT; s++)
          if (!done && re[s] && raddr[s] == row[p]) begin
            gnt[p]      = 1'b1;
            gnt_slot[p] = SLOT_W'(s);
            done        = 1'b1;
          end
        // slots fill in order, so the first idle one is the lowest free index
        for (int s = 0; s < BANK_RPORT; s++)
          if (!done && !re[s]) begin
            re[s]       = 1'b1;
            raddr[s]    = row[p];
            gnt[p]      = 1'b1;
            gnt_slot[p] = SLOT_W'(s);
            done        = 1'b1;
          end
        if (done) ptr_nxt = (p == LAST) ? '0 : p + 1'b1;
      end
      p = (p == LAST) ? '0 : p + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else        ptr <= ptr_nxt;
endmodule

// File: rtl/vrf_bank_rd_arb.sv
// VRF read-port arbiter: per-bank slot allocation, one-cycle response stage.
module vrf_bank_rd_arb
  import vrf_bank_rd_arb_pkg::*;
#(
  parameter int RPORT_NUM  = VRF_RPORT_NUM,
  parameter int BANK_NUM   = VRF_BANK_NUM,
  parameter int BANK_RPORT = VRF_PREBANK_RPORT,
  parameter int ADDR_W     = VERG_ADDR_WIDTH,
  parameter int DATA_W     = VFULEN,
  parameter int TAG_W      = VRF_TAG_W,
  localparam int BANK_W    = $clog2(BANK_NUM),
  localparam int ROW_W     = ADDR_W - BANK_W,
  localparam int SLOT_W    = (BANK_RPORT > 1) ? $clog2(BANK_RPORT) : 1
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           flush,
  input  logic [RPORT_NUM-1:0]                           req_vld,
  output logic [RPORT_NUM-1:0]                           req_rdy,
  input  logic [RPORT_NUM-1:0][ADDR_W-1:0]               req_addr,
  input  logic [RPORT_NUM-1:0][TAG_W-1:0]                req_tag,
  output logic [BANK_NUM-1:0][BANK_RPORT-1:0]            bank_re,
  output logic [BANK_NUM-1:0][BANK_RPORT-1:0][ROW_W-1:0] bank_raddr,
  input  logic [BANK_NUM-1:0][BANK_RPORT-1:0][DATA_W-1:0] bank_rdata,
  output logic [RPORT_NUM-1:0]                           rsp_vld,
  output logic [RPORT_NUM-1:0][DATA_W-1:0]               rsp_data,
  output logic [RPORT_NUM-1:0][TAG_W-1:0]                rsp_tag
);
  logic [RPORT_NUM-1:0][BANK_W-1:0]               bank_sel;
  logic [RPORT_NUM-1:0][ROW_W-1:0]                row;
  logic [BANK_NUM-1:0][RPORT_NUM-1:0]             hit, gnt;
  logic [BANK_NUM-1:0][RPORT_NUM-1:0][SLOT_W-1:0] gnt_slot;
  logic [RPORT_NUM-1:0][SLOT_W-1:0]               slot_sel;

  always_comb begin
    hit = '0;
    for (int p = 0; p < RPORT_NUM; p++) begin
      bank_sel[p] = req_addr[p][BANK_W-1:0];
      row[p]      = req_addr[p][ADDR_W-1:BANK_W];
      hit[bank_sel[p]][p] = req_vld[p];
    end
  end

  for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
    vrf_bank_slot_alloc #(
      .RPORT_NUM (RPORT_NUM),
      .BANK_RPORT(BANK_RPORT),
      .ROW_W     (ROW_W)
    ) u_alloc (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (flush),
      .hit     (hit[b]),
      .row     (row),
      .gnt     (gnt[b]),
      .gnt_slot(gnt_slot[b]),
      .re      (bank_re[b]),
      .raddr   (bank_raddr[b])
    );
  end

  always_comb begin
    for (int p = 0; p < RPORT_NUM; p++) begin
      req_rdy[p]  = gnt[bank_sel[p]][p];
      slot_sel[p] = gnt_slot[bank_sel[p]][p];
    end
  end

  // Response stage: remember which bank slot each accepted port landed in.
  logic [RPORT_NUM-1:0]             rsp_vld_q;
  logic [RPORT_NUM-1:0][BANK_W-1:0] rsp_bank;
  logic [RPORT_NUM-1:0][SLOT_W-1:0] rsp_slot;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rsp_vld_q <= '0;
    else        rsp_vld_q <= req_rdy;

  always_ff @(posedge clk)
    for (int p = 0; p < RPORT_NUM; p++)
      if (req_rdy[p]) begin
        rsp_bank[p] <= bank_sel[p];
        rsp_slot[p] <= slot_sel[p];
        rsp_tag[p]  <= req_tag[p];
      end

  assign rsp_vld = rsp_vld_q & {RPORT_NUM{~flush}};

  always_comb
    for (int p = 0; p < RPORT_NUM; p++)
      rsp_data[p] = bank_rdata[rsp_bank[p]][rsp_slot[p]];
endmodule

// File: tb/tb_vrf_bank_rd_arb.sv
// Directed vector bench for vrf_bank_rd_arb with a behavioural bank memory.
module tb_vrf_bank_rd_arb;
  import vrf_bank_rd_arb_pkg::*;
  localparam int NP = 5, NB = 4, NS = 2, AW = 6, DW = 256, TW = 18, RW = 4;
  localparam int NV = 12;

  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic [NP-1:0]                 req_vld, req_rdy, rsp_vld;
  logic [NP-1:0][AW-1:0]         req_addr;
  logic [NP-1:0][TW-1:0]         req_tag, rsp_tag;
  logic [NB-1:0][NS-1:0]         bank_re;
  logic [NB-1:0][NS-1:0][RW-1:0] bank_raddr;
  logic [NB-1:0][NS-1:0][DW-1:0] bank_rdata;
  logic [NP-1:0][DW-1:0]         rsp_data;
  int total = 0, bad = 0;

  typedef struct packed {
    logic                  fl;
    logic [NP-1:0]         vld;
    logic [NP-1:0][AW-1:0] addr;
    logic [NP-1:0]         rdy;
    logic [NB-1:0][NS-1:0] re;
  } vec_t;
  vec_t vecs[NV];

  always #5 clk = ~clk;

  vrf_bank_rd_arb dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_addr(req_addr), .req_tag(req_tag),
    .bank_re(bank_re), .bank_raddr(bank_raddr), .bank_rdata(bank_rdata),
    .rsp_vld(rsp_vld), .rsp_data(rsp_data), .rsp_tag(rsp_tag)
  );

  function automatic logic [DW-1:0] mk(input logic [1:0] b, input logic [RW-1:0] r);
    mk = {{(DW-16){1'b1}}, 6'h0, b, 4'h0, r};
  endfunction

  function automatic logic [TW-1:0] tg(input int p, input logic [AW-1:0] a);
    tg = {4'(p), a, 8'hA5};
  endfunction

  function automatic vec_t mkv(input logic fl, input logic [NP-1:0] vld,
                               input logic [NP*AW-1:0] addr, input logic [NP-1:0] rdy,
                               input logic [NB*NS-1:0] re);
    mkv.fl = fl; mkv.vld = vld; mkv.addr = addr; mkv.rdy = rdy; mkv.re = re;
  endfunction

  // bank memory: row data one cycle after a slot read enable
  always @(posedge clk)
    for (int b = 0; b < NB; b++)
      for (int s = 0; s < NS; s++)
        bank_rdata[b][s] <= bank_re[b][s] ? mk(2'(b), bank_raddr[b][s]) : '0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    flush    = v.fl;
    req_vld  = v.vld;
    req_addr = v.addr;
    for (int p = 0; p < NP; p++) req_tag[p] = tg(p, v.addr[p]);
  endtask

  initial begin
    vec_t prev, v;
    logic [NP-1:0] exp_vld;

    vecs[0]  = mkv(0, 5'b00000, '0, 5'b00000, 8'h00);
    vecs[1]  = mkv(0, 5'b11111, {6'h10, 6'h0C, 6'h08, 6'h04, 6'h00}, 5'b00011, 8'h03);
    vecs[2]  = mkv(0, 5'b11100, {6'h10, 6'h0C, 6'h08, 6'h04, 6'h00}, 5'b01100, 8'h03);
    vecs[3]  = mkv(0, 5'b10000, {6'h10, 6'h0C, 6'h08, 6'h04, 6'h00}, 5'b10000, 8'h01);
    vecs[4]  = mkv(0, 5'b01011, {6'h00, 6'h05, 6'h00, 6'h09, 6'h05}, 5'b01011, 8'h0C);
    vecs[5]  = mkv(0, 5'b11111, {6'd4, 6'd3, 6'd2, 6'd1, 6'd0},     5'b11111, 8'h57);
    vecs[6]  = mkv(0, 5'b00000, '0, 5'b00000, 8'h00);
    vecs[7]  = mkv(1, 5'b01111, {6'h00, 6'h0D, 6'h09, 6'h05, 6'h01}, 5'b00000, 8'h00);
    vecs[8]  = mkv(0, 5'b01111, {6'h00, 6'h0D, 6'h09, 6'h05, 6'h01}, 5'b01100, 8'h0C);
    vecs[9]  = mkv(0, 5'b00011, {6'h00, 6'h0D, 6'h09, 6'h05, 6'h01}, 5'b00011, 8'h0C);
    vecs[10] = mkv(1, 5'b00000, '0, 5'b00000, 8'h00);
    vecs[11] = mkv(0, 5'b00000, '0, 5'b00000, 8'h00);

    req_vld = '0; req_addr = '0; req_tag = '0;
    repeat (2) @(negedge clk);
    chk("rst_rsp_vld", rsp_vld, '0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #2;
      chk("idle_rsp_vld", rsp_vld, '0);
      chk("idle_req_rdy", req_rdy, '0);
      chk("idle_bank_re", bank_re, '0);
    end

    prev = vecs[0];
    prev.rdy = '0;
    for (int k = 0; k < NV; k++) begin
      v = vecs[k];
      @(negedge clk);
      drive(v);
      #2;
      chk($sformatf("v%0d_req_rdy", k), req_rdy, v.rdy);
      chk($sformatf("v%0d_bank_re", k), bank_re, v.re);
      exp_vld = prev.rdy & {NP{~v.fl}};
      chk($sformatf("v%0d_rsp_vld", k), rsp_vld, exp_vld);
      for (int p = 0; p < NP; p++)
        if (exp_vld[p]) begin
          chk($sformatf("v%0d_p%0d_data", k, p), rsp_data[p],
              mk(prev.addr[p][1:0], prev.addr[p][AW-1:2]));
          chk($sformatf("v%0d_p%0d_tag", k, p), rsp_tag[p], tg(p, prev.addr[p]));
        end
      prev = v;
    end

    // reset lands while a response is in flight
    @(negedge clk);
    flush = 1'b0; req_vld = 5'b00001; req_addr[0] = 6'h06; req_tag[0] = tg(0, 6'h06);
    #2 chk("mid_req_rdy", req_rdy, 5'b00001);
    @(negedge clk);
    req_vld = '0;
    #2;
    chk("mid_rsp_vld_pre", rsp_vld, 5'b00001);
    chk("mid_rsp_data_pre", rsp_data[0], mk(2'd2, 4'd1));
    #1 rst_n = 1'b0;
    #1 chk("mid_rsp_vld_rst", rsp_vld, '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #2;
      chk("mid_rsp_vld_post", rsp_vld, '0);
      chk("mid_req_rdy_post", req_rdy, '0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vrf_bank_rd_arb.md
VRF_BANK_RD_ARB -- requirements
Module: vrf_bank_rd_arb

Interface
REQ-001 Parameter RPORT_NUM, default 5: number of requester read ports.
REQ-002 Parameter BANK_NUM, default 4: number of VRF banks, power of two.
REQ-003 Parameter BANK_RPORT, default 2: read slots per bank per cycle.
REQ-004 Parameter ADDR_W, default 6: uvrf address width.
REQ-005 Parameter DATA_W, default 256: read data width (VFULEN).
REQ-006 Parameter TAG_W, default 18: opaque tag carrying rs_idx and field idx.
REQ-007 Ports:
- clk  in  1  clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  kill request.
- req_vld  in  RPORT_NUM  per-port read request.
- req_rdy  out  RPORT_NUM  per-port grant, combinational.
- req_addr  in  RPORT_NUM x ADDR_W  uvrf address.
- req_tag  in  RPORT_NUM x TAG_W  request tag.
- bank_re  out  BANK_NUM x BANK_RPORT  bank slot read enable.
- bank_raddr  out  BANK_NUM x BANK_RPORT x (ADDR_W-log2(BANK_NUM))  bank row address.
- bank_rdata  in  BANK_NUM x BANK_RPORT x DATA_W  slot data, valid one cycle after bank_re.
- rsp_vld  out  RPORT_NUM  response valid.
- rsp_data  out  RPORT_NUM x DATA_W  response data.
- rsp_tag  out  RPORT_NUM x TAG_W  echoed tag.

Function
REQ-008 Bank index SHALL be req_addr[log2(BANK_NUM)-1:0]; row SHALL be the remaining upper bits.
REQ-009 Each bank SHALL keep a round-robin pointer over ports; ports SHALL be examined in order pointer, pointer+1, ... with wrap modulo RPORT_NUM.
REQ-010 A port SHALL be granted when its address equals one already allocated to a slot of that bank this cycle (merge, no slot consumed), or when a free slot remains (lowest free slot index allocated).
REQ-011 Ports not granted SHALL see req_rdy=0 and SHALL hold vld/addr/tag stable until granted.
REQ-012 bank_re SHALL be 1 exactly for allocated slots; bank_raddr SHALL be don't-care otherwise.
REQ-013 A request accepted in cycle T SHALL produce rsp_vld=1 in cycle T+1, with rsp_data = bank_rdata of its allocated slot and rsp_tag = registered req_tag; there is no response backpressure.
REQ-014 When a bank grants at least one port, its pointer SHALL advance to one past the last granted port in scan order (modulo RPORT_NUM); otherwise it SHALL hold.
REQ-015 Any continuously valid request SHALL be granted within ceil(RPORT_NUM/BANK_RPORT) cycles.
REQ-016 flush=1 in cycle T SHALL force req_rdy=0 and bank_re=0 in T, mask rsp_vld to 0 in T, and hold all pointers.
REQ-017 Merged ports SHALL each receive their own rsp_vld and tag with identical rsp_data.

Reset
REQ-018 rst_n low SHALL asynchronously clear all rsp_vld registers and all bank pointers to 0; rsp_tag/rsp_data registers need no reset.
REQ-019 With no valid requests, req_rdy and bank_re SHALL be 0 in every cycle, including directly after reset.
REQ-020 Reset asserted mid-operation SHALL drop pending responses immediately; none SHALL be replayed.

Structure
REQ-021 Defaults (VRF_RPORT_NUM, VRF_BANK_NUM, VRF_PREBANK_RPORT, VERG_ADDR_WIDTH, VFULEN) and request/response struct typedefs SHALL live in the shared vector parameter package.
REQ-022 Per-bank slot allocation and pointer SHALL be one sub-module, vrf_bank_slot_alloc, instantiated BANK_NUM times; the response stage is in the top.

Verification
REQ-023 Reset: rst_n low then high with req_vld=0 -> rsp_vld=0, req_rdy=0, bank_re=0 for 10 cycles.
REQ-024 Conflict: ports 0-4 at addrs 0x00,0x04,0x08,0x0C,0x10 (all bank0), held until granted -> cycle1 grants p0,p1; cycle2 p2,p3; cycle3 p4; each rsp one cycle after its grant.
REQ-025 Merge: p0=0x05, p3=0x05, p1=0x09 -> all granted same cycle, bank1 uses 2 slots, p0 and p3 rsp_data equal.
REQ-026 Spread: p0-p4 at 0,1,2,3,4 -> all granted in one cycle, bank0 slots 0 and 1 used.
REQ-027 Flush: flush=1 with 4 valid requests -> no rdy, no bank_re, pointers unchanged; next cycle grants per REQ-010.
REQ-028 Mid-op reset: rst_n low in the cycle after acceptance -> rsp_vld=0 immediately and no response after release.
